cnn_conv_layer: RTL and testbench
=================================

# cnn_conv_layer

Parametrised multi-channel 2-D convolution layer: streams a raster-order feature map of CI channels (one pixel per valid beat), builds a KY×KX sliding window per channel, and computes CO output channels with bias, arithmetic requantisation, optional ReLU and saturation. Adds stride, frame tracking and output clamping to the single-channel 5×5 core. It sits between the pixel source and the pooling/next-layer stage of the CNN datapath.

## Interface
- I_F_BW, 8: input pixel width, unsigned
- KX, KY, 5, 5: kernel width/height
- IX, IY, 28, 28: input frame width/height
- CI, 1: input channels
- CO, 3: output channels
- W_BW, 7: weight width, signed two's complement
- B_BW, 7: bias width, signed
- STRIDE, 1: window step in both axes (1..KX)
- SHIFT, 0: arithmetic right shift applied after bias add
- O_F_BW, 8: output width, signed
- AB_BW, derived localparam = I_F_BW+W_BW+2+clog2(CI·KX·KY): accumulator width
- clk, in, 1: clock
- reset, in, 1: asynchronous, active-high reset
- i_cnn_weight, in, CO·CI·KY·KX·W_BW: packed [co][ci][ky][kx], kx fastest; static during a frame
- i_cnn_bias, in, CO·B_BW: packed [co]; static during a frame
- i_relu_en, in, 1: 1 = clamp negatives to 0; static during a frame
- i_in_valid, in, 1: pixel beat valid; no backpressure
- i_in_fmap, in, CI·I_F_BW: pixel for all channels, [ci] packed
- o_ot_valid, out, 1: output beat valid
- o_ot_fmap, out, CO·O_F_BW: output pixel, [co] packed
- o_frame_done, out, 1: one-cycle pulse coincident with the last output beat of a frame

## Operation
- Column counter col (0..IX-1) and row counter row (0..IY-1) advance on each accepted beat; col wraps to 0 and row increments; after (IY-1, IX-1) both return to 0 (next beat starts a new frame).
- Per channel: KY-1 line buffers of IX pixels plus a KY×KX window register, shifted on accepted beats only.
- A beat at (row, col) completes a window when row ≥ KY-1, col ≥ KX-1, (row-KY+1) mod STRIDE = 0 and (col-KX+1) mod STRIDE = 0. Output dims: OX=(IX-KX)/STRIDE+1, OY likewise.
- Arithmetic: product = $signed({1'b0,pixel}) × weight; sum over ci, ky, kx in AB_BW bits; add sign-extended bias; arithmetic shift right by SHIFT; if i_relu_en and result < 0 → 0; saturate to [-2^(O_F_BW-1), 2^(O_F_BW-1)-1].
- Window shift uses the beat being accepted; the window tagged valid is the one including that beat.
- Reset mid-frame: counters, valid pipeline and outputs clear; line-buffer contents are not cleared (stale data is never emitted because the window condition requires KY-1 fresh rows).

## Timing
- Pipeline stages: S1 window register; S2 registered products; S3 registered sum plus bias; S4 registered shift/ReLU/saturate.
- Latency: a window-completing beat accepted at cycle t → o_ot_valid at t+4. Fixed, independent of gaps in i_in_valid.
- Valid is a shift-tagged pipeline; input gaps appear as equal gaps at the output, and back-to-back completing beats give back-to-back outputs.
- o_frame_done asserts with the output of beat (IY-1, IX-1) when that beat completes a window; otherwise it asserts 4 cycles after that beat with o_ot_valid low.
- Reset values: o_ot_valid=0, o_ot_fmap=0, o_frame_done=0, col=row=0.
- o_ot_fmap holds its last value while o_ot_valid=0.

## Structure
- Shared package cnn_pkg: clog2 function, AB_BW derivation, signed saturate helper, packing index macros for weight [co][ci][ky][kx].
- One sub-module: cnn_window_gen (per-channel line buffers + window + row/col counters + window-valid/frame-last tags), instantiated once with CI-wide pixels.
- MAC tree, bias and requantisation inline in cnn_conv_layer, generate loop over CO.

## Test plan
- IX=IY=6, K=3, CI=1, CO=1, all weights 1, bias 0, pixels = 1: 16 outputs of 9, first at t+4 after beat (2,2), o_frame_done with 16th.
- STRIDE=2, same frame: exactly 4 outputs (windows at rows/cols 2 and 4); no output for odd-offset beats.
- Weights all -64, pixel 255, ReLU off, SHIFT=0, O_F_BW=8: output saturates to -128; ReLU on: output 0.
- CI=2, CO=2, ch0 pixel=2, ch1 pixel=3, co0 weights (1,0), co1 weights (0,-1), bias (5,-5): outputs 23 and -32.
- Random i_in_valid gaps (50%) vs. continuous stream: identical output sequence, per-beat latency exactly 4.
- Assert reset at row 3 of a frame, then restart a fresh frame: no output before the new beat (KY-1, KX-1); results match golden model.

Source files
------------

// File: rtl/cnn_pkg.sv
// cnn_pkg: sizing, weight packing and saturation helpers shared by the convolution layer.
package cnn_pkg;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int ab_bw(input int i_bw, w_bw, ci, kx, ky);
    return i_bw + w_bw + 2 + clog2(ci * kx * ky);
  endfunction
  // flat element index of weight [co][ci][ky][kx], kx fastest
  function automatic int w_idx(input int co, ci, ky, kx, n_ci, n_ky, n_kx);
    return ((co * n_ci + ci) * n_ky + ky) * n_kx + kx;
  endfunction
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int bw);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (bw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return v > hi ? hi : v < lo ? lo : v;
  endfunction
endpackage

// File: rtl/cnn_conv_layer_if.sv
// cnn_conv_layer_if: raster pixel stream into the layer and convolved pixel stream out.
interface cnn_conv_layer_if #(parameter int CI = 1, I_F_BW = 8, CO = 3, O_F_BW = 8);
  logic in_valid;
  logic [CI*I_F_BW-1:0] in_fmap;
  logic ot_valid;
  logic [CO*O_F_BW-1:0] ot_fmap;
  logic frame_done;
  modport master (output in_valid, in_fmap, input ot_valid, ot_fmap, frame_done);
  modport slave (input in_valid, in_fmap, output ot_valid, ot_fmap, frame_done);
endinterface

// File: rtl/cnn_window_gen.sv
// cnn_window_gen: per-channel line buffers feeding a KYxKX window, raster counters,
// and the window-complete / frame-last tags of the beat just accepted.
module cnn_window_gen
  import cnn_pkg::*;
#(parameter int IX = 28, IY = 28, KX = 5, KY = 5, CI = 1, I_F_BW = 8, STRIDE = 1)
(
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  input  logic [CI*I_F_BW-1:0] in_fmap,
  output logic [CI-1:0][KY-1:0][KX-1:0][I_F_BW-1:0] win,
  output logic win_valid,
  output logic frame_last
);
  localparam int CW = clog2(IX);
  localparam int RW = clog2(IY);
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [I_F_BW-1:0] lb [CI][KY-1][IX];
  logic done, last_col, last_row;
  always_comb begin
    last_col = int'(col) == IX - 1;
    last_row = int'(row) == IY - 1;
    done = int'(row) >= KY - 1 && int'(col) >= KX - 1 &&
           (int'(row) - KY + 1) % STRIDE == 0 && (int'(col) - KX + 1) % STRIDE == 0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      col <= '0;
      row <= '0;
      win_valid <= 1'b0;
      frame_last <= 1'b0;
    end else begin
      win_valid <= in_valid && done;
      frame_last <= in_valid && last_col && last_row;
      if (in_valid) begin
        col <= last_col ? '0 : col + 1'b1;
        row <= last_col ? (last_row ? '0 : row + 1'b1) : row;
      end
    end
  // lb[c][j] is an IX-deep delay chain, so its tail is the pixel j+1 rows above
  always_ff @(posedge clk)
    if (in_valid)
      for (int c = 0; c < CI; c++) begin
        lb[c][0][0] <= in_fmap[c*I_F_BW +: I_F_BW];
        for (int y = 1; y < KY - 1; y++) lb[c][y][0] <= lb[c][y-1][IX-1];
        for (int y = 0; y < KY - 1; y++) begin
          for (int x = 1; x < IX; x++) lb[c][y][x] <= lb[c][y][x-1];
          win[c][y][KX-1] <= lb[c][KY-2-y][IX-1];
        end
        win[c][KY-1][KX-1] <= in_fmap[c*I_F_BW +: I_F_BW];
        for (int y = 0; y < KY; y++)
          for (int x = 0; x < KX - 1; x++) win[c][y][x] <= win[c][y][x+1];
      end
endmodule

// File: rtl/cnn_conv_layer.sv
// cnn_conv_layer: multi-channel KYxKX convolution with bias, arithmetic shift,
// optional ReLU and saturation; fixed four-stage pipeline behind the window generator.
module cnn_conv_layer
  import cnn_pkg::*;
#(parameter int I_F_BW = 8, KX = 5, KY = 5, IX = 28, IY = 28, CI = 1, CO = 3,
  W_BW = 7, B_BW = 7, STRIDE = 1, SHIFT = 0, O_F_BW = 8)
(
  input logic clk,
  input logic reset,
  input logic [CO*CI*KY*KX*W_BW-1:0] i_cnn_weight,
  input logic [CO*B_BW-1:0] i_cnn_bias,
  input logic i_relu_en,
  cnn_conv_layer_if.slave s
);
  localparam int AB_BW = ab_bw(I_F_BW, W_BW, CI, KX, KY);
  localparam int N = CI * KY * KX;
  localparam int PW = I_F_BW + W_BW + 1;
  logic [CI-1:0][KY-1:0][KX-1:0][I_F_BW-1:0] win;
  logic win_valid, frame_last, v2, f2, v3, f3;
  logic [CO*O_F_BW-1:0] res;
  cnn_window_gen #(.IX(IX), .IY(IY), .KX(KX), .KY(KY), .CI(CI), .I_F_BW(I_F_BW), .STRIDE(STRIDE)) u_win (
    .clk, .reset, .in_valid(s.in_valid), .in_fmap(s.in_fmap), .win, .win_valid, .frame_last
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      {v2, f2, v3, f3} <= '0;
      s.ot_valid <= 1'b0;
      s.frame_done <= 1'b0;
      s.ot_fmap <= '0;
    end else begin
      v2 <= win_valid;
      f2 <= frame_last;
      v3 <= v2;
      f3 <= f2;
      s.ot_valid <= v3;
      s.frame_done <= f3;
      if (v3) s.ot_fmap <= res;
    end
  for (genvar o = 0; o < CO; o++) begin : g_co
    logic signed [PW-1:0] prod [N];
    logic signed [AB_BW-1:0] sum, acc;
    logic signed [63:0] r;
    always_ff @(posedge clk) begin
      for (int c = 0; c < CI; c++)
        for (int y = 0; y < KY; y++)
          for (int x = 0; x < KX; x++)
            prod[(c*KY+y)*KX+x] <= PW'($signed({1'b0, win[c][y][x]})) *
              PW'($signed(i_cnn_weight[w_idx(o, c, y, x, CI, KY, KX)*W_BW +: W_BW]));
      acc <= sum;
    end
    always_comb begin
      sum = AB_BW'($signed(i_cnn_bias[o*B_BW +: B_BW]));
      for (int i = 0; i < N; i++) sum = sum + AB_BW'(prod[i]);
    end
    always_comb begin
      r = 64'(acc) >>> SHIFT;
      r = i_relu_en && r < 0 ? 64'sd0 : r;
    end
    assign res[o*O_F_BW +: O_F_BW] = O_F_BW'(sat(r, O_F_BW));
  end
endmodule

// File: tb/tb_cnn_conv_layer.sv
// tb_cnn_conv_layer: scoreboard bench over a stride-1 layer, a stride-2 layer with shift,
// and a two-channel-in / two-channel-out layer, all on a 6x6 frame with a 3x3 kernel.
module tb_cnn_conv_layer;
  localparam int N = 6, K = 3;
  typedef struct {int t; bit v; bit fd; int d0; int d1;} exp_t;
  logic clk = 0, reset = 1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int checks = 0, errors = 0;
  logic [7:0] img [2][N][N];
  int wt [2][2][K][K];
  int bs [2];
  logic relu = 0;
  logic [K*K*7-1:0] w0;
  logic [4*K*K*7-1:0] w2;
  exp_t q [3][$];
  int last [3][2];
  int outs [3];

  always_comb begin
    w0 = '0;
    w2 = '0;
    for (int y = 0; y < K; y++)
      for (int x = 0; x < K; x++) begin
        w0[(y*K+x)*7 +: 7] = 7'(wt[0][0][y][x]);
        for (int o = 0; o < 2; o++)
          for (int c = 0; c < 2; c++) w2[(((o*2+c)*K+y)*K+x)*7 +: 7] = 7'(wt[o][c][y][x]);
      end
  end

  cnn_conv_layer_if #(.CI(1), .I_F_BW(8), .CO(1), .O_F_BW(8)) b0 (), b1 ();
  cnn_conv_layer_if #(.CI(2), .I_F_BW(8), .CO(2), .O_F_BW(8)) b2 ();

  cnn_conv_layer #(.I_F_BW(8), .KX(K), .KY(K), .IX(N), .IY(N), .CI(1), .CO(1), .W_BW(7), .B_BW(7),
    .STRIDE(1), .SHIFT(0), .O_F_BW(8)) d0 (.clk(clk), .reset(reset), .i_cnn_weight(w0),
    .i_cnn_bias(7'(bs[0])), .i_relu_en(relu), .s(b0));
  cnn_conv_layer #(.I_F_BW(8), .KX(K), .KY(K), .IX(N), .IY(N), .CI(1), .CO(1), .W_BW(7), .B_BW(7),
    .STRIDE(2), .SHIFT(1), .O_F_BW(8)) d1 (.clk(clk), .reset(reset), .i_cnn_weight(w0),
    .i_cnn_bias(7'(bs[0])), .i_relu_en(relu), .s(b1));
  cnn_conv_layer #(.I_F_BW(8), .KX(K), .KY(K), .IX(N), .IY(N), .CI(2), .CO(2), .W_BW(7), .B_BW(7),
    .STRIDE(1), .SHIFT(0), .O_F_BW(8)) d2 (.clk(clk), .reset(reset), .i_cnn_weight(w2),
    .i_cnn_bias({7'(bs[1]), 7'(bs[0])}), .i_relu_en(relu), .s(b2));

  function automatic int model(int d, int co, int r, int c);
    int acc = bs[co];
    for (int ci = 0; ci < (d == 2 ? 2 : 1); ci++)
      for (int y = 0; y < K; y++)
        for (int x = 0; x < K; x++)
          acc += int'(img[ci][r-K+1+y][c-K+1+x]) * wt[co][ci][y][x];
    acc = acc >>> (d == 1 ? 1 : 0);
    if (relu && acc < 0) acc = 0;
    return acc > 127 ? 127 : acc < -128 ? -128 : acc;
  endfunction

  task automatic mon(int d, logic v, logic fd, logic [15:0] f);
    exp_t e;
    int a0, a1;
    a0 = int'($signed(f[7:0]));
    a1 = int'($signed(f[15:8]));
    if (q[d].size() > 0 && q[d][0].t == cyc) begin
      e = q[d].pop_front();
      checks++;
      assert ({v, fd} === {e.v, e.fd}) else begin
        errors++;
        $error("FAIL tags d%0d cyc %0d: got v=%b fd=%b, want v=%b fd=%b", d, cyc, v, fd, e.v, e.fd);
      end
      if (e.v) begin
        outs[d]++;
        checks++;
        assert (a0 === e.d0 && a1 === e.d1) else begin
          errors++;
          $error("FAIL data d%0d cyc %0d: got %0d/%0d, want %0d/%0d", d, cyc, a0, a1, e.d0, e.d1);
        end
      end
    end else begin
      checks++;
      assert ({v, fd} === 2'b00) else begin
        errors++;
        $error("FAIL spurious d%0d cyc %0d: got v=%b fd=%b, want 0 0", d, cyc, v, fd);
      end
    end
    if (reset) begin
      last[d][0] = 0;
      last[d][1] = 0;
    end else if (!v) begin
      checks++;
      assert (a0 === last[d][0] && a1 === last[d][1]) else begin
        errors++;
        $error("FAIL hold d%0d cyc %0d: got %0d/%0d, want %0d/%0d", d, cyc, a0, a1, last[d][0], last[d][1]);
      end
    end else begin
      last[d][0] = a0;
      last[d][1] = a1;
    end
  endtask

  always @(negedge clk) begin
    mon(0, b0.ot_valid, b0.frame_done, {8'h00, b0.ot_fmap});
    mon(1, b1.ot_valid, b1.frame_done, {8'h00, b1.ot_fmap});
    mon(2, b2.ot_valid, b2.frame_done, b2.ot_fmap);
  end

  task automatic idle();
    @(posedge clk);
    #1;
    b0.in_valid = 0;
    b1.in_valid = 0;
    b2.in_valid = 0;
  endtask

  task automatic beat(int d, int r, int c);
    exp_t e;
    int st;
    st = d == 1 ? 2 : 1;
    @(posedge clk);
    #1;
    b0.in_valid = d == 0;
    b1.in_valid = d == 1;
    b2.in_valid = d == 2;
    b0.in_fmap = img[0][r][c];
    b1.in_fmap = img[0][r][c];
    b2.in_fmap = {img[1][r][c], img[0][r][c]};
    e.t = cyc + 4;
    e.v = r >= K - 1 && c >= K - 1 && (r - K + 1) % st == 0 && (c - K + 1) % st == 0;
    e.fd = r == N - 1 && c == N - 1;
    e.d0 = e.v ? model(d, 0, r, c) : 0;
    e.d1 = e.v && d == 2 ? model(d, 1, r, c) : 0;
    if (e.v || e.fd) q[d].push_back(e);
  endtask

  task automatic frame(int d, int gap, int n);
    for (int i = 0; i < n; i++) begin
      while (gap > 0 && int'($urandom_range(99)) < gap) idle();
      beat(d, i / N, i % N);
    end
  endtask

  task automatic drain(int d);
    repeat (6) idle();
    checks++;
    assert (q[d].size() === 0) else begin
      errors++;
      $error("FAIL drain d%0d: %0d outputs still pending, want 0", d, q[d].size());
    end
  endtask

  task automatic count_is(int d, int want);
    checks++;
    assert (outs[d] === want) else begin
      errors++;
      $error("FAIL count d%0d: got %0d outputs, want %0d", d, outs[d], want);
    end
    outs[d] = 0;
  endtask

  task automatic set_img(int ci, int v);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) img[ci][r][c] = 8'(v);
  endtask

  task automatic rand_img(int ci);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) img[ci][r][c] = 8'($urandom_range(15));
  endtask

  task automatic set_w(int co, int ci, int v);
    for (int y = 0; y < K; y++)
      for (int x = 0; x < K; x++) wt[co][ci][y][x] = v;
  endtask

  task automatic rand_w();
    for (int o = 0; o < 2; o++)
      for (int c = 0; c < 2; c++)
        for (int y = 0; y < K; y++)
          for (int x = 0; x < K; x++) wt[o][c][y][x] = int'($urandom_range(6)) - 3;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    b0.in_valid = 0; b1.in_valid = 0; b2.in_valid = 0;
    b0.in_fmap = '0; b1.in_fmap = '0; b2.in_fmap = '0;
    set_img(0, 0); set_img(1, 0);
    set_w(0, 0, 0); set_w(0, 1, 0); set_w(1, 0, 0); set_w(1, 1, 0);
    bs[0] = 0; bs[1] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    assert ({b0.ot_valid, b0.frame_done, b0.ot_fmap, b1.ot_valid, b1.frame_done, b1.ot_fmap} === 20'h0) else begin
      errors++;
      $error("FAIL reset d0/d1: got %b %b %h / %b %b %h, want all 0", b0.ot_valid, b0.frame_done, b0.ot_fmap,
             b1.ot_valid, b1.frame_done, b1.ot_fmap);
    end
    checks++;
    assert ({b2.ot_valid, b2.frame_done, b2.ot_fmap} === 18'h0) else begin
      errors++;
      $error("FAIL reset d2: got %b %b %h, want all 0", b2.ot_valid, b2.frame_done, b2.ot_fmap);
    end
    @(posedge clk);
    #1 reset = 0;
    // all-ones frame: sixteen outputs of 9, frame_done on the last
    set_img(0, 1); set_w(0, 0, 1);
    frame(0, 0, N * N); drain(0); count_is(0, 16);
    // stride 2 with shift 1: four outputs of 4, frame_done alone on the last beat
    frame(1, 0, N * N); drain(1); count_is(1, 4);
    // saturation and ReLU
    set_img(0, 255); set_w(0, 0, -64);
    frame(0, 0, N * N); drain(0); count_is(0, 16);
    relu = 1;
    frame(0, 0, N * N); drain(0); count_is(0, 16);
    relu = 0; set_w(0, 0, 63);
    frame(0, 0, N * N); drain(0); count_is(0, 16);
    // two channels in, two out: 23 and -32
    set_img(0, 2); set_img(1, 3);
    set_w(0, 0, 1); set_w(0, 1, 0); set_w(1, 0, 0); set_w(1, 1, -1);
    bs[0] = 5; bs[1] = -5;
    frame(2, 0, N * N); drain(2); count_is(2, 16);
    // random data, continuous then gapped input
    rand_img(0); rand_img(1); rand_w();
    bs[0] = int'($urandom_range(20)) - 10; bs[1] = int'($urandom_range(20)) - 10;
    frame(0, 0, N * N); drain(0); count_is(0, 16);
    frame(0, 50, N * N); drain(0); count_is(0, 16);
    frame(2, 50, N * N); drain(2); count_is(2, 16);
    frame(1, 50, N * N); drain(1); count_is(1, 4);
    // reset in row 3, then a fresh frame with new pixels
    relu = 1;
    frame(0, 0, 3 * N + 3);
    @(posedge clk);
    #1;
    reset = 1;
    q[0].delete();
    b0.in_valid = 0;
    outs[0] = 0;
    @(negedge clk);
    checks++;
    assert ({b0.ot_valid, b0.frame_done, b0.ot_fmap} === 10'h0) else begin
      errors++;
      $error("FAIL midreset d0: got %b %b %h, want all 0", b0.ot_valid, b0.frame_done, b0.ot_fmap);
    end
    @(posedge clk);
    #1 reset = 0;
    rand_img(0);
    frame(0, 0, N * N); drain(0); count_is(0, 16);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
